reorder_buffer: RTL and testbench

//   Circular in-order commit queue for the out-of-order core. It allocates an entry
//   per issued instruction and takes results from the reservation station (ALU) and
//   the load/store buffer. Entries retire in program order: the ROB drives the commit

---
 rtl/reorder_buffer.sv | 249 ++++++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order commit queue: allocates an entry per issued instruction, collects
// ALU/LSB results, retires in program order and flushes the pipeline on a mispredict.
module reorder_buffer #(
    parameter int CAP     = 16,
    parameter int IDX_BIT = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,

    input  logic               inst_req,
    input  logic [4:0]         inst_rd,
    input  logic               inst_is_branch,
    input  logic               inst_is_store,
    input  logic               inst_pred_taken,
    input  logic [31:0]        inst_alt_pc,
    output logic [IDX_BIT-1:0] tail_id,
    output logic               full,

    input  logic               rs_ready,
    input  logic [IDX_BIT-1:0] rs_rob_id,
    input  logic [31:0]        rs_result,
    input  logic               lsb_ready,
    input  logic [IDX_BIT-1:0] lsb_rob_id,
    input  logic [31:0]        lsb_result,

    input  logic [IDX_BIT-1:0] qry1_id,
    input  logic [IDX_BIT-1:0] qry2_id,
    output logic               qry1_ready,
    output logic               qry2_ready,
    output logic [31:0]        qry1_val,
    output logic [31:0]        qry2_val,

    output logic               cdb_req,
    output logic [IDX_BIT-1:0] cdb_rob_id,
    output logic [31:0]        cdb_val,
    output logic [4:0]         cdb_rd,
    output logic               store_commit,
    output logic               clear,
    output logic [31:0]        clear_pc
);

    localparam int CNT_W = IDX_BIT + 1;

    // Control state
    logic [IDX_BIT-1:0] head_q, head_d;
    logic [IDX_BIT-1:0] tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q  [CAP];
    logic               busy_d  [CAP];
    logic               ready_q [CAP];
    logic               ready_d [CAP];

    // Entry payload
    logic [4:0]         rd_q        [CAP];
    logic [4:0]         rd_d        [CAP];
    logic               is_branch_q [CAP];
    logic               is_branch_d [CAP];
    logic               is_store_q  [CAP];
    logic               is_store_d  [CAP];
    logic               pred_q      [CAP];
    logic               pred_d      [CAP];
    logic [31:0]        alt_pc_q    [CAP];
    logic [31:0]        alt_pc_d    [CAP];
    logic [31:0]        val_q       [CAP];
    logic [31:0]        val_d       [CAP];

    // Registered outputs
    logic               full_q, full_d;
    logic               cdb_req_q, cdb_req_d;
    logic [IDX_BIT-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic [31:0]        cdb_val_q, cdb_val_d;
    logic [4:0]         cdb_rd_q, cdb_rd_d;
    logic               store_commit_q, store_commit_d;
    logic               clear_q, clear_d;
    logic [31:0]        clear_pc_q, clear_pc_d;

    logic               take_issue;
    logic               take_rs;
    logic               take_lsb;
    logic               head_commit;
    logic               head_mispredict;

    // The cycle after a flush (clear_q=1) drops every incoming request.
    always_comb begin
        take_issue      = rdy_in && !clear_q && inst_req;
        take_rs         = rdy_in && !clear_q && rs_ready  && busy_q[rs_rob_id];
        take_lsb        = rdy_in && !clear_q && lsb_ready && busy_q[lsb_rob_id];
        head_commit     = rdy_in && busy_q[head_q] && ready_q[head_q];
        head_mispredict = head_commit && is_branch_q[head_q]
                          && (val_q[head_q][0] != pred_q[head_q]);
    end

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        busy_d         = busy_q;
        ready_d        = ready_q;
        rd_d           = rd_q;
        is_branch_d    = is_branch_q;
        is_store_d     = is_store_q;
        pred_d         = pred_q;
        alt_pc_d       = alt_pc_q;
        val_d          = val_q;
        full_d         = full_q;
        cdb_req_d      = 1'b0;
        cdb_rob_id_d   = cdb_rob_id_q;
        cdb_val_d      = cdb_val_q;
        cdb_rd_d       = cdb_rd_q;
        store_commit_d = 1'b0;
        clear_d        = 1'b0;
        clear_pc_d     = clear_pc_q;

        // lsb first so rs wins when both target the same id
        if (take_lsb) begin
            ready_d[lsb_rob_id] = 1'b1;
            val_d[lsb_rob_id]   = lsb_result;
        end
        if (take_rs) begin
            ready_d[rs_rob_id] = 1'b1;
            val_d[rs_rob_id]   = rs_result;
        end

        if (head_commit) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + IDX_BIT'(1);
            if (head_mispredict) begin
                clear_d    = 1'b1;
                clear_pc_d = alt_pc_q[head_q];
            end else if (is_store_q[head_q]) begin
                store_commit_d = 1'b1;
            end else if (!is_branch_q[head_q]) begin
                cdb_req_d    = 1'b1;
                cdb_rob_id_d = head_q;
                cdb_val_d    = val_q[head_q];
                cdb_rd_d     = rd_q[head_q];
            end
        end

        if (take_issue) begin
            busy_d[tail_q]      = 1'b1;
            ready_d[tail_q]     = 1'b0;
            rd_d[tail_q]        = inst_rd;
            is_branch_d[tail_q] = inst_is_branch;
            is_store_d[tail_q]  = inst_is_store;
            pred_d[tail_q]      = inst_pred_taken;
            alt_pc_d[tail_q]    = inst_alt_pc;
            tail_d              = tail_q + IDX_BIT'(1);
        end

        count_d = count_q + CNT_W'(take_issue) - CNT_W'(head_commit);

        // A mispredict discards everything younger, including a same-cycle issue.
        if (head_mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            for (int i = 0; i < CAP; i++) begin
                busy_d[i] = 1'b0;
            end
        end

        // Two-slot threshold leaves room for an issue already in flight.
        if (rdy_in) begin
            full_d = (count_d >= CNT_W'(CAP - 2));
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            cdb_req_q      <= 1'b0;
            cdb_rob_id_q   <= '0;
            cdb_val_q      <= '0;
            cdb_rd_q       <= '0;
            store_commit_q <= 1'b0;
            clear_q        <= 1'b0;
            clear_pc_q     <= '0;
            for (int i = 0; i < CAP; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
            end
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            full_q         <= full_d;
            cdb_req_q      <= cdb_req_d;
            cdb_rob_id_q   <= cdb_rob_id_d;
            cdb_val_q      <= cdb_val_d;
            cdb_rd_q       <= cdb_rd_d;
            store_commit_q <= store_commit_d;
            clear_q        <= clear_d;
            clear_pc_q     <= clear_pc_d;
            busy_q         <= busy_d;
            ready_q        <= ready_d;
        end
    end

    // Payload is only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk_in) begin
        rd_q        <= rd_d;
        is_branch_q <= is_branch_d;
        is_store_q  <= is_store_d;
        pred_q      <= pred_d;
        alt_pc_q    <= alt_pc_d;
        val_q       <= val_d;
    end

    // Operand lookup with same-cycle writeback forwarding.
    always_comb begin
        qry1_ready = busy_q[qry1_id] && ready_q[qry1_id];
        qry1_val   = val_q[qry1_id];
        if (lsb_ready && lsb_rob_id == qry1_id) begin
            qry1_ready = 1'b1;
            qry1_val   = lsb_result;
        end
        if (rs_ready && rs_rob_id == qry1_id) begin
            qry1_ready = 1'b1;
            qry1_val   = rs_result;
        end

        qry2_ready = busy_q[qry2_id] && ready_q[qry2_id];
        qry2_val   = val_q[qry2_id];
        if (lsb_ready && lsb_rob_id == qry2_id) begin
            qry2_ready = 1'b1;
            qry2_val   = lsb_result;
        end
        if (rs_ready && rs_rob_id == qry2_id) begin
            qry2_ready = 1'b1;
            qry2_val   = rs_result;
        end
    end

    assign tail_id      = tail_q;
    assign full         = full_q;
    assign cdb_req      = cdb_req_q;
    assign cdb_rob_id   = cdb_rob_id_q;
    assign cdb_val      = cdb_val_q;
    assign cdb_rd       = cdb_rd_q;
    assign store_commit = store_commit_q;
    assign clear        = clear_q;
    assign clear_pc     = clear_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic checked
// against a program-order reference list.
module tb_reorder_buffer;

    localparam int CAP     = 16;
    localparam int IDX_BIT = 4;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               rdy_in;
    logic               inst_req;
    logic [4:0]         inst_rd;
    logic               inst_is_branch;
    logic               inst_is_store;
    logic               inst_pred_taken;
    logic [31:0]        inst_alt_pc;
    logic [IDX_BIT-1:0] tail_id;
    logic               full;
    logic               rs_ready;
    logic [IDX_BIT-1:0] rs_rob_id;
    logic [31:0]        rs_result;
    logic               lsb_ready;
    logic [IDX_BIT-1:0] lsb_rob_id;
    logic [31:0]        lsb_result;
    logic [IDX_BIT-1:0] qry1_id;
    logic [IDX_BIT-1:0] qry2_id;
    logic               qry1_ready;
    logic               qry2_ready;
    logic [31:0]        qry1_val;
    logic [31:0]        qry2_val;
    logic               cdb_req;
    logic [IDX_BIT-1:0] cdb_rob_id;
    logic [31:0]        cdb_val;
    logic [4:0]         cdb_rd;
    logic               store_commit;
    logic               clear;
    logic [31:0]        clear_pc;

    reorder_buffer #(.CAP(CAP), .IDX_BIT(IDX_BIT)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .inst_req(inst_req), .inst_rd(inst_rd), .inst_is_branch(inst_is_branch),
        .inst_is_store(inst_is_store), .inst_pred_taken(inst_pred_taken),
        .inst_alt_pc(inst_alt_pc), .tail_id(tail_id), .full(full),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_result(rs_result),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_result(lsb_result),
        .qry1_id(qry1_id), .qry2_id(qry2_id), .qry1_ready(qry1_ready),
        .qry2_ready(qry2_ready), .qry1_val(qry1_val), .qry2_val(qry2_val),
        .cdb_req(cdb_req), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val), .cdb_rd(cdb_rd),
        .store_commit(store_commit), .clear(clear), .clear_pc(clear_pc)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    // Commit monitor: {id, val, rd} per cdb pulse, with the cycle it was seen.
    logic [40:0] cdb_log[$];
    int          cdb_cyc[$];
    logic [40:0] exp_q[$];
    int          cyc       = 0;
    int          clear_cnt = 0;
    int          store_cnt = 0;

    always @(negedge clk_in) begin
        cyc <= cyc + 1;
        if (!rst_in) begin
            if (cdb_req) begin
                cdb_log.push_back({cdb_rob_id, cdb_val, cdb_rd});
                cdb_cyc.push_back(cyc);
            end
            if (clear)        clear_cnt <= clear_cnt + 1;
            if (store_commit) store_cnt <= store_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_idle();
        inst_req        = 1'b0;
        inst_rd         = '0;
        inst_is_branch  = 1'b0;
        inst_is_store   = 1'b0;
        inst_pred_taken = 1'b0;
        inst_alt_pc     = '0;
        rs_ready        = 1'b0;
        rs_rob_id       = '0;
        rs_result       = '0;
        lsb_ready       = 1'b0;
        lsb_rob_id      = '0;
        lsb_result      = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rdy_in = 1'b1;
        rst_in = 1'b1;
        repeat (2) tick();
        rst_in = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic br, input logic st,
                         input logic pred, input logic [31:0] alt);
        inst_req        = 1'b1;
        inst_rd         = rd;
        inst_is_branch  = br;
        inst_is_store   = st;
        inst_pred_taken = pred;
        inst_alt_pc     = alt;
        tick();
        inst_req        = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rdy_in = 1'b1;
        rst_in = 1'b1;
        repeat (2) tick();
        n_checks++; if (tail_id !== 4'd0) $display("FAIL reset_tail_id: got %0d expected 0", tail_id); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else n_pass++;
        n_checks++; if (cdb_req !== 1'b0) $display("FAIL reset_cdb_req: got %b expected 0", cdb_req); else n_pass++;
        n_checks++; if (clear !== 1'b0) $display("FAIL reset_clear: got %b expected 0", clear); else n_pass++;
        n_checks++; if (store_commit !== 1'b0) $display("FAIL reset_store_commit: got %b expected 0", store_commit); else n_pass++;
        n_checks++; if (cdb_val !== 32'd0) $display("FAIL reset_cdb_val: got %h expected 0", cdb_val); else n_pass++;
        n_checks++; if (clear_pc !== 32'd0) $display("FAIL reset_clear_pc: got %h expected 0", clear_pc); else n_pass++;
        rst_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (full !== 1'b0 || tail_id !== 4'd0) $display("FAIL idle_state: got full=%b tail=%0d expected full=0 tail=0", full, tail_id); else n_pass++;
            n_checks++; if ({cdb_req, clear, store_commit} !== 3'b000) $display("FAIL idle_pulses: got %b expected 000", {cdb_req, clear, store_commit}); else n_pass++;
        end
    endtask

    task automatic test_in_order();
        int base;
        do_reset();
        base = cdb_log.size();
        exp_q.delete();
        for (int i = 1; i <= 3; i++) begin
            logic [4:0] rd;
            rd = 5'(i);
            issue(rd, 1'b0, 1'b0, 1'b0, 32'd0);
            n_checks++; if (tail_id !== 4'(i)) $display("FAIL inorder_tail: got %0d expected %0d", tail_id, i); else n_pass++;
        end
        rs_ready = 1'b1; rs_rob_id = 4'd2; rs_result = 32'd7; tick();
        rs_rob_id = 4'd0; rs_result = 32'd5; tick();
        rs_rob_id = 4'd1; rs_result = 32'd6; tick();
        drive_idle();
        for (int w = 0; w < 10 && cdb_log.size() < base + 3; w++) tick();
        exp_q.push_back({4'd0, 32'd5, 5'd1});
        exp_q.push_back({4'd1, 32'd6, 5'd2});
        exp_q.push_back({4'd2, 32'd7, 5'd3});
        n_checks++; if (cdb_log.size() !== base + 3) $display("FAIL inorder_count: got %0d expected %0d", cdb_log.size() - base, 3); else n_pass++;
        for (int i = 0; i < 3 && base + i < cdb_log.size(); i++) begin
            logic [40:0] got;
            got = cdb_log[base + i];
            n_checks++; if (got !== exp_q[i]) $display("FAIL inorder_commit[%0d]: got %h expected %h", i, got, exp_q[i]); else n_pass++;
            if (i > 0) begin
                n_checks++; if (cdb_cyc[base + i] - cdb_cyc[base + i - 1] !== 1) $display("FAIL inorder_spacing[%0d]: got gap %0d expected 1", i, cdb_cyc[base + i] - cdb_cyc[base + i - 1]); else n_pass++;
            end
        end
    endtask

    task automatic test_full();
        int base;
        do_reset();
        base = cdb_log.size();
        for (int i = 0; i < 14; i++) begin
            logic [4:0] rd;
            rd = 5'(i + 1);
            issue(rd, 1'b0, 1'b0, 1'b0, 32'd0);
            if (i == 12) begin
                n_checks++; if (full !== 1'b0) $display("FAIL full_at_13: got %b expected 0", full); else n_pass++;
            end
        end
        n_checks++; if (full !== 1'b1) $display("FAIL full_at_14: got %b expected 1", full); else n_pass++;
        n_checks++; if (tail_id !== 4'd14) $display("FAIL full_tail: got %0d expected 14", tail_id); else n_pass++;
        repeat (4) tick();
        n_checks++; if (cdb_log.size() !== base) $display("FAIL full_no_commit: got %0d commits expected 0", cdb_log.size() - base); else n_pass++;
        n_checks++; if (full !== 1'b1) $display("FAIL full_hold: got %b expected 1", full); else n_pass++;
    endtask

    task automatic test_pause();
        int base;
        do_reset();
        base = cdb_log.size();
        issue(5'd4, 1'b0, 1'b0, 1'b0, 32'd0);
        rs_ready = 1'b1; rs_rob_id = 4'd0; rs_result = 32'h33; tick();
        drive_idle();
        rdy_in   = 1'b0;
        inst_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (cdb_req !== 1'b0 || tail_id !== 4'd1) $display("FAIL pause_hold: got cdb_req=%b tail=%0d expected 0/1", cdb_req, tail_id); else n_pass++;
        end
        inst_req = 1'b0;
        rdy_in   = 1'b1;
        tick();
        n_checks++; if ({cdb_req, cdb_rob_id, cdb_val, cdb_rd} !== {1'b1, 4'd0, 32'h33, 5'd4}) $display("FAIL pause_resume: got req=%b id=%0d val=%h rd=%0d expected 1/0/33/4", cdb_req, cdb_rob_id, cdb_val, cdb_rd); else n_pass++;
        tick();
        n_checks++; if (cdb_log.size() !== base + 1) $display("FAIL pause_count: got %0d expected 1", cdb_log.size() - base); else n_pass++;
    endtask

    task automatic test_mispredict();
        int base, cbase;
        do_reset();
        base  = cdb_log.size();
        cbase = clear_cnt;
        issue(5'd0, 1'b1, 1'b0, 1'b0, 32'h100);
        issue(5'd5, 1'b0, 1'b0, 1'b0, 32'd0);
        rs_ready  = 1'b1; rs_rob_id  = 4'd0; rs_result  = 32'd1;
        lsb_ready = 1'b1; lsb_rob_id = 4'd1; lsb_result = 32'h55;
        tick();
        drive_idle();
        tick();
        n_checks++; if (clear !== 1'b1) $display("FAIL mp_clear: got %b expected 1", clear); else n_pass++;
        n_checks++; if (clear_pc !== 32'h100) $display("FAIL mp_clear_pc: got %h expected 100", clear_pc); else n_pass++;
        n_checks++; if (cdb_req !== 1'b0) $display("FAIL mp_cdb: got %b expected 0", cdb_req); else n_pass++;
        inst_req = 1'b1; inst_rd = 5'd9;
        rs_ready = 1'b1; rs_rob_id = 4'd0; rs_result = 32'd3;
        tick();
        drive_idle();
        n_checks++; if (clear !== 1'b0) $display("FAIL mp_clear_one_cycle: got %b expected 0", clear); else n_pass++;
        n_checks++; if (tail_id !== 4'd0 || full !== 1'b0) $display("FAIL mp_flushed: got tail=%0d full=%b expected 0/0", tail_id, full); else n_pass++;
        repeat (3) tick();
        n_checks++; if (cdb_log.size() !== base) $display("FAIL mp_no_cdb: got %0d expected 0", cdb_log.size() - base); else n_pass++;
        n_checks++; if (clear_cnt - cbase !== 1) $display("FAIL mp_clear_count: got %0d expected 1", clear_cnt - cbase); else n_pass++;
    endtask

    task automatic test_branch_store();
        int cbase;
        do_reset();
        cbase = clear_cnt;
        issue(5'd0, 1'b1, 1'b0, 1'b1, 32'h200);
        issue(5'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        issue(5'd7, 1'b0, 1'b0, 1'b0, 32'd0);
        rs_ready  = 1'b1; rs_rob_id  = 4'd0; rs_result  = 32'd1;
        lsb_ready = 1'b1; lsb_rob_id = 4'd1; lsb_result = 32'hdead;
        tick();
        lsb_ready = 1'b0; rs_rob_id = 4'd2; rs_result = 32'h77;
        tick();
        drive_idle();
        n_checks++; if ({cdb_req, clear, store_commit} !== 3'b000) $display("FAIL bs_branch_quiet: got %b expected 000", {cdb_req, clear, store_commit}); else n_pass++;
        tick();
        n_checks++; if ({cdb_req, store_commit} !== 2'b01) $display("FAIL bs_store: got req/st=%b expected 01", {cdb_req, store_commit}); else n_pass++;
        tick();
        n_checks++; if ({cdb_req, cdb_rob_id, cdb_val, cdb_rd, store_commit} !== {1'b1, 4'd2, 32'h77, 5'd7, 1'b0}) $display("FAIL bs_normal: got req=%b id=%0d val=%h rd=%0d st=%b expected 1/2/77/7/0", cdb_req, cdb_rob_id, cdb_val, cdb_rd, store_commit); else n_pass++;
        n_checks++; if (clear_cnt - cbase !== 0) $display("FAIL bs_no_clear: got %0d expected 0", clear_cnt - cbase); else n_pass++;
    endtask

    task automatic test_forward();
        int base;
        do_reset();
        base = cdb_log.size();
        exp_q.delete();
        issue(5'd1, 1'b0, 1'b0, 1'b0, 32'd0);
        issue(5'd2, 1'b0, 1'b0, 1'b0, 32'd0);
        issue(5'd3, 1'b0, 1'b0, 1'b0, 32'd0);
        qry1_id = 4'd1; qry2_id = 4'd0;
        #1;
        n_checks++; if (qry1_ready !== 1'b0) $display("FAIL fwd_not_ready: got %b expected 0", qry1_ready); else n_pass++;
        rs_ready  = 1'b1; rs_rob_id  = 4'd0; rs_result  = 32'd9;
        lsb_ready = 1'b1; lsb_rob_id = 4'd1; lsb_result = 32'd4;
        #1;
        n_checks++; if ({qry1_ready, qry1_val} !== {1'b1, 32'd4}) $display("FAIL fwd_lsb: got %b/%h expected 1/4", qry1_ready, qry1_val); else n_pass++;
        n_checks++; if ({qry2_ready, qry2_val} !== {1'b1, 32'd9}) $display("FAIL fwd_rs: got %b/%h expected 1/9", qry2_ready, qry2_val); else n_pass++;
        tick();
        rs_rob_id = 4'd2; rs_result = 32'h11;
        lsb_rob_id = 4'd2; lsb_result = 32'h22;
        qry1_id = 4'd2;
        #1;
        n_checks++; if ({qry1_ready, qry1_val} !== {1'b1, 32'h11}) $display("FAIL fwd_rs_priority: got %b/%h expected 1/11", qry1_ready, qry1_val); else n_pass++;
        n_checks++; if ({qry2_ready, qry2_val} !== {1'b1, 32'd9}) $display("FAIL fwd_stored: got %b/%h expected 1/9", qry2_ready, qry2_val); else n_pass++;
        tick();
        drive_idle();
        for (int w = 0; w < 10 && cdb_log.size() < base + 3; w++) tick();
        exp_q.push_back({4'd0, 32'd9, 5'd1});
        exp_q.push_back({4'd1, 32'd4, 5'd2});
        exp_q.push_back({4'd2, 32'h11, 5'd3});
        n_checks++; if (cdb_log.size() !== base + 3) $display("FAIL fwd_count: got %0d expected 3", cdb_log.size() - base); else n_pass++;
        for (int i = 0; i < 3 && base + i < cdb_log.size(); i++) begin
            n_checks++; if (cdb_log[base + i] !== exp_q[i]) $display("FAIL fwd_commit[%0d]: got %h expected %h", i, cdb_log[base + i], exp_q[i]); else n_pass++;
        end
        if (cdb_log.size() >= base + 2) begin
            n_checks++; if (cdb_cyc[base + 1] - cdb_cyc[base] !== 1) $display("FAIL fwd_spacing: got gap %0d expected 1", cdb_cyc[base + 1] - cdb_cyc[base]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int base;
        logic [31:0] sv[20];
        logic [4:0]  sr[20];
        do_reset();
        base = cdb_log.size();
        exp_q.delete();
        for (int k = 0; k < 20; k++) begin
            logic [3:0] id;
            id    = 4'(k % CAP);
            sv[k] = $urandom;
            sr[k] = 5'($urandom_range(0, 31));
            exp_q.push_back({id, sv[k], sr[k]});
        end
        for (int k = 0; k <= 20; k++) begin
            drive_idle();
            if (k < 20) begin
                inst_req = 1'b1;
                inst_rd  = sr[k];
            end
            if (k > 0) begin
                rs_ready  = 1'b1;
                rs_rob_id = 4'((k - 1) % CAP);
                rs_result = sv[k - 1];
            end
            tick();
            n_checks++; if (full !== 1'b0) $display("FAIL stream_full[%0d]: got %b expected 0", k, full); else n_pass++;
        end
        drive_idle();
        for (int w = 0; w < 30 && cdb_log.size() < base + 20; w++) tick();
        n_checks++; if (cdb_log.size() !== base + 20) $display("FAIL stream_count: got %0d expected 20", cdb_log.size() - base); else n_pass++;
        for (int i = 0; i < 20 && base + i < cdb_log.size(); i++) begin
            n_checks++; if (cdb_log[base + i] !== exp_q[i]) $display("FAIL stream_commit[%0d]: got %h expected %h", i, cdb_log[base + i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (tail_id !== 4'd4) $display("FAIL stream_tail_wrap: got %0d expected 4", tail_id); else n_pass++;
    endtask

    // Random mix of ALU ops, loads, stores and correctly predicted branches, issued in
    // bursts of at most 10 with out-of-order writebacks; the expected commit stream is
    // simply program order over the non-store, non-branch entries.
    task automatic test_random();
        int base, sbase, cbase, exp_st, timeouts;
        logic [3:0] tail_m;
        do_reset();
        base = cdb_log.size(); sbase = store_cnt; cbase = clear_cnt;
        exp_q.delete();
        exp_st = 0; timeouts = 0; tail_m = 4'd0;
        for (int ph = 0; ph < 6; ph++) begin
            int n, issued, guard;
            logic [3:0]  e_id[10];
            logic [31:0] e_val[10];
            logic        e_lsb[10];
            int pend[$];
            n = $urandom_range(1, 10);
            issued = 0; guard = 0;
            while ((issued < n || pend.size() > 0) && guard < 200) begin
                int rs_p, lsb_p, new_idx;
                rs_p = -1; lsb_p = -1; new_idx = -1;
                drive_idle();
                for (int k = 0; k < pend.size(); k++) begin
                    if (!e_lsb[pend[k]] && rs_p < 0 && $urandom_range(0, 1) == 1) rs_p = k;
                    if (e_lsb[pend[k]] && lsb_p < 0 && $urandom_range(0, 1) == 1) lsb_p = k;
                end
                if (rs_p >= 0) begin
                    rs_ready = 1'b1; rs_rob_id = e_id[pend[rs_p]]; rs_result = e_val[pend[rs_p]];
                end
                if (lsb_p >= 0) begin
                    lsb_ready = 1'b1; lsb_rob_id = e_id[pend[lsb_p]]; lsb_result = e_val[pend[lsb_p]];
                end
                if (rs_p > lsb_p) begin
                    pend.delete(rs_p);
                    if (lsb_p >= 0) pend.delete(lsb_p);
                end else if (lsb_p >= 0) begin
                    pend.delete(lsb_p);
                    if (rs_p >= 0) pend.delete(rs_p);
                end
                if (issued < n && $urandom_range(0, 2) != 0) begin
                    int kind;
                    logic [4:0] rd;
                    logic pred;
                    kind = $urandom_range(0, 2);
                    rd   = 5'($urandom_range(0, 31));
                    pred = 1'($urandom_range(0, 1));
                    new_idx = issued;
                    e_id[issued] = tail_m;
                    tail_m = tail_m + 4'd1;
                    inst_req = 1'b1; inst_rd = rd; inst_pred_taken = pred;
                    inst_alt_pc = $urandom;
                    if (kind == 0) begin
                        e_val[issued] = $urandom;
                        e_lsb[issued] = 1'($urandom_range(0, 1));
                        exp_q.push_back({e_id[issued], e_val[issued], rd});
                    end else if (kind == 1) begin
                        inst_is_store = 1'b1;
                        e_val[issued] = $urandom;
                        e_lsb[issued] = 1'b1;
                        exp_st++;
                    end else begin
                        inst_is_branch = 1'b1;
                        e_val[issued] = {31'($urandom), pred};
                        e_lsb[issued] = 1'b0;
                    end
                    issued++;
                end
                tick();
                if (new_idx >= 0) pend.push_back(new_idx);
                guard++;
            end
            if (guard >= 200) timeouts++;
            drive_idle();
            for (int w = 0; w < 40 && (cdb_log.size() < base + exp_q.size() || store_cnt - sbase < exp_st); w++) tick();
            tick();
        end
        n_checks++; if (timeouts !== 0) $display("FAIL rand_timeout: got %0d expected 0", timeouts); else n_pass++;
        n_checks++; if (cdb_log.size() - base !== exp_q.size()) $display("FAIL rand_count: got %0d expected %0d", cdb_log.size() - base, exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && base + i < cdb_log.size(); i++) begin
            n_checks++; if (cdb_log[base + i] !== exp_q[i]) $display("FAIL rand_commit[%0d]: got %h expected %h", i, cdb_log[base + i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (store_cnt - sbase !== exp_st) $display("FAIL rand_stores: got %0d expected %0d", store_cnt - sbase, exp_st); else n_pass++;
        n_checks++; if (clear_cnt - cbase !== 0) $display("FAIL rand_clear: got %0d expected 0", clear_cnt - cbase); else n_pass++;
        n_checks++; if (tail_id !== tail_m) $display("FAIL rand_tail: got %0d expected %0d", tail_id, tail_m); else n_pass++;
    endtask

    initial begin
        rst_in  = 1'b1;
        rdy_in  = 1'b1;
        qry1_id = '0;
        qry2_id = '0;
        drive_idle();
        test_reset();
        test_in_order();
        test_full();
        test_pause();
        test_mispredict();
        test_branch_store();
        test_forward();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
